// File: rtl/program_counter_pkg.sv
// Shared types for the program counter slice: register selectors, microcode phase, load enables.
package program_counter_pkg;

    localparam int unsigned PC_WIDTH     = 13;
    localparam int unsigned NP_WIDTH     = 5;
    localparam int unsigned PCS_WIDTH    = 8;
    localparam int unsigned NIBBLE_WIDTH = 4;

    typedef enum logic [3:0] {
        REG_NONE             = 4'h0,
        REG_NPP              = 4'h1,
        REG_SETPC            = 4'h2,
        REG_SETPCVEC         = 4'h3,
        REG_JPBAEND          = 4'h4,
        REG_CALLEND_SET_PCP  = 4'h5,
        REG_CALLEND_ZERO_PCP = 4'h6,
        REG_PCSH             = 4'h7,
        REG_PCSL             = 4'h8,
        REG_PCP              = 4'h9,
        REG_PCP_EARLY        = 4'hA
    } reg_type;

    typedef enum logic [1:0] {
        CYCLE_FETCH     = 2'd0,
        CYCLE_DECODE    = 2'd1,
        CYCLE_REG_READ  = 2'd2,
        CYCLE_REG_WRITE = 2'd3
    } microcode_cycle;

    typedef struct packed {
        logic npp;
        logic setpc;
        logic setpcvec;
        logic jpbaend;
        logic callend_set_pcp;
        logic callend_zero_pcp;
        logic pcsh;
        logic pcsl;
        logic pcp_early;
    } pc_load_t;

    // True when any load enable touches PCB/PCP/PCS (NPP loads excluded).
    function automatic logic pc_write_any(input pc_load_t ld);
        return ld.setpc | ld.setpcvec | ld.jpbaend | ld.callend_set_pcp |
               ld.callend_zero_pcp | ld.pcsh | ld.pcsl | ld.pcp_early;
    endfunction

endpackage

// File: rtl/pc_write_decode.sv
// Decodes the write selector into one-hot load enables, qualified by the register-write phase.
module pc_write_decode
    import program_counter_pkg::*;
(
    input  microcode_cycle current_cycle,
    input  reg_type        bus_output_selector,
    output pc_load_t       load_c
);

    always_comb begin
        load_c = '0;
        if (current_cycle == CYCLE_REG_WRITE) begin
            case (bus_output_selector)
                REG_NPP:              load_c.npp              = 1'b1;
                REG_SETPC:            load_c.setpc            = 1'b1;
                REG_SETPCVEC:         load_c.setpcvec         = 1'b1;
                REG_JPBAEND:          load_c.jpbaend          = 1'b1;
                REG_CALLEND_SET_PCP:  load_c.callend_set_pcp  = 1'b1;
                REG_CALLEND_ZERO_PCP: load_c.callend_zero_pcp = 1'b1;
                REG_PCSH:             load_c.pcsh             = 1'b1;
                REG_PCSL:             load_c.pcsl             = 1'b1;
                REG_PCP_EARLY:        load_c.pcp_early        = 1'b1;
                default:              load_c                  = '0;
            endcase
        end
    end

endmodule

// File: rtl/program_counter.sv
// CPU program counter {PCB,PCP,PCS} and new-page pointer {NBP,NPP}.
// Optional breakpoint comparator enabled by defining PROGRAM_COUNTER_BREAKPOINT_EN.
module program_counter
    import program_counter_pkg::*;
#(
    parameter logic [3:0] RESET_PCP  = 4'h1,
    parameter logic [3:0] VECTOR_PCP = 4'h1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                increment_pc,
    input  logic                reset_np,
    input  microcode_cycle      current_cycle,
    input  reg_type             bus_output_selector,
    input  reg_type             bus_input_selector,
    input  logic [3:0]          bus_data,
    input  logic [7:0]          immediate,
    input  logic [3:0]          reg_a,
    input  logic [3:0]          reg_b,
    input  logic [2:0]          interrupt_vector,
    output logic [PC_WIDTH-1:0] pc,
    output logic [NP_WIDTH-1:0] np,
    output logic [3:0]          read_data
`ifdef PROGRAM_COUNTER_BREAKPOINT_EN
    ,
    input  logic                bp_valid,
    input  logic [PC_WIDTH-1:0] bp_addr,
    output logic                bp_hit
`endif
);

    logic                    pcb_q, pcb_d;
    logic [NIBBLE_WIDTH-1:0] pcp_q, pcp_d;
    logic [PCS_WIDTH-1:0]    pcs_q, pcs_d;
    logic                    nbp_q, nbp_d;
    logic [NIBBLE_WIDTH-1:0] npp_q, npp_d;
    pc_load_t                load_c;

    pc_write_decode u_decode (
        .current_cycle       (current_cycle),
        .bus_output_selector (bus_output_selector),
        .load_c              (load_c)
    );

    // Next PC: any explicit write replaces the increment; nibble writes hold the other nibble.
    always_comb begin
        pcb_d = pcb_q;
        pcp_d = pcp_q;
        pcs_d = pcs_q;
        if (pc_write_any(load_c)) begin
            if (load_c.setpc) begin
                pcb_d = nbp_q;
                pcp_d = npp_q;
                pcs_d = immediate;
            end
            if (load_c.setpcvec) begin
                pcb_d = 1'b0;
                pcp_d = VECTOR_PCP;
                pcs_d = {4'h0, interrupt_vector, 1'b0};
            end
            if (load_c.jpbaend) begin
                pcb_d = nbp_q;
                pcp_d = npp_q;
                pcs_d = {reg_b, reg_a};
            end
            if (load_c.callend_set_pcp) begin
                pcp_d = npp_q;
                pcs_d = immediate;
            end
            if (load_c.callend_zero_pcp) begin
                pcp_d = 4'h0;
                pcs_d = immediate;
            end
            if (load_c.pcsh) begin
                pcs_d = {bus_data, pcs_q[3:0]};
            end
            if (load_c.pcsl) begin
                pcs_d = {pcs_q[7:4], bus_data};
            end
            if (load_c.pcp_early) begin
                pcp_d = bus_data;
            end
        end else if (increment_pc) begin
            pcs_d = PCS_WIDTH'(pcs_q + 8'd1);
        end
    end

    // Next NP: explicit NPP load beats the copy from the pre-edge PC.
    always_comb begin
        nbp_d = nbp_q;
        npp_d = npp_q;
        if (load_c.npp) begin
            nbp_d = immediate[4];
            npp_d = bus_data;
        end else if (reset_np) begin
            nbp_d = pcb_q;
            npp_d = pcp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcb_q <= 1'b0;
            pcp_q <= RESET_PCP;
            pcs_q <= 8'h00;
            nbp_q <= 1'b0;
            npp_q <= RESET_PCP;
        end else begin
            pcb_q <= pcb_d;
            pcp_q <= pcp_d;
            pcs_q <= pcs_d;
            nbp_q <= nbp_d;
            npp_q <= npp_d;
        end
    end

    assign pc = {pcb_q, pcp_q, pcs_q};
    assign np = {nbp_q, npp_q};

    // Return-address nibbles for CALL pushes.
    always_comb begin
        read_data = 4'h0;
        case (bus_input_selector)
            REG_PCSH: read_data = pcs_q[7:4];
            REG_PCSL: read_data = pcs_q[3:0];
            REG_PCP:  read_data = pcp_q;
            default:  read_data = 4'h0;
        endcase
    end

`ifdef PROGRAM_COUNTER_BREAKPOINT_EN
    logic bp_match_c;
    logic bp_match_q;

    assign bp_match_c = bp_valid && (pc == bp_addr);

    // Rising-edge detect so a PC parked on the address fires once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bp_match_q <= 1'b0;
            bp_hit     <= 1'b0;
        end else begin
            bp_match_q <= bp_match_c;
            bp_hit     <= bp_match_c && !bp_match_q;
        end
    end
`endif

endmodule
